// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, instruction field positions, fetch state encoding.
package cpu_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // Instruction field bit positions
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int RS_MSB   = 25;
    localparam int RS_LSB   = 21;
    localparam int RT_MSB   = 20;
    localparam int RT_LSB   = 16;
    localparam int RD_MSB   = 15;
    localparam int RD_LSB   = 11;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;
    localparam int FUNC_MSB = 3;
    localparam int FUNC_LSB = 0;

    // Fetch state encoding
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // Sign-extend a 16-bit immediate to 32 bits
    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC / next-state selection for the fetch stage.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter logic [5:0]  HALT_OP = OP_HALT
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] pc_plus1,
    input  logic [31:0]       instr,
    input  logic [0:0]        state,
    input  logic              stall,
    input  logic              jump,
    input  logic              branch_taken,
    output logic [ADDR_W-1:0] pc_next,
    output logic [0:0]        state_next,
    output logic              retire
);

    logic [31:0] branch_sum;

    // Branch target computed at 32 bits; truncation gives the modulo-2^ADDR_W wrap
    always_comb begin
        branch_sum = {{(32-ADDR_W){1'b0}}, pc_plus1} + sext16(instr[IMM_MSB:IMM_LSB]);
    end

    // Priority: halt state > stall > HALT opcode > jump > branch > sequential
    always_comb begin
        pc_next    = pc;
        state_next = state;
        retire     = 1'b0;
        if (state == ST_RUN && !stall) begin
            retire = 1'b1;
            if (instr[OP_MSB:OP_LSB] == HALT_OP) begin
                state_next = ST_HALT;
            end else if (jump) begin
                pc_next = instr[ADDR_W-1:0];
            end else if (branch_taken) begin
                pc_next = branch_sum[ADDR_W-1:0];
            end else begin
                pc_next = pc_plus1;
            end
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: PC register, field split, halt FSM and retire counter.
module pc_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]  HALT_OP  = OP_HALT
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              jump,
    input  logic              branch_taken,
    output logic [5:0]        op,
    output logic [3:0]        func,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       imm16,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              valid,
    output logic              halted,
    output logic [31:0]       retired
);

    logic [0:0]        state;
    logic [0:0]        state_next;
    logic [ADDR_W-1:0] pc_next;
    logic              retire;

    pc_next_sel #(
        .ADDR_W  (ADDR_W),
        .HALT_OP (HALT_OP)
    ) u_pc_next_sel (
        .pc           (pc),
        .pc_plus1     (pc_plus1),
        .instr        (imem_rdata),
        .state        (state),
        .stall        (stall),
        .jump         (jump),
        .branch_taken (branch_taken),
        .pc_next      (pc_next),
        .state_next   (state_next),
        .retire       (retire)
    );

    // PC, state and retire counter; reset is asynchronous and overrides everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            state   <= ST_RUN;
            retired <= '0;
        end else begin
            pc    <= pc_next;
            state <= state_next;
            if (retire) begin
                retired <= retired + 32'd1;
            end
        end
    end

    // Field split and status; op/func zeroed in HALT so downstream writes stay idle
    always_comb begin
        imem_addr = pc;
        pc_plus1  = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        valid     = (state == ST_RUN);
        halted    = (state == ST_HALT);
        rs        = imem_rdata[RS_MSB:RS_LSB];
        rt        = imem_rdata[RT_MSB:RT_LSB];
        rd        = imem_rdata[RD_MSB:RD_LSB];
        imm16     = imem_rdata[IMM_MSB:IMM_LSB];
        op        = halted ? 6'd0 : imem_rdata[OP_MSB:OP_LSB];
        func      = halted ? 4'd0 : imem_rdata[FUNC_MSB:FUNC_LSB];
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch.
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        jump;
    logic        branch_taken;
    logic [5:0]  op;
    logic [3:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic [7:0]  pc;
    logic [7:0]  pc_plus1;
    logic        valid;
    logic        halted;
    logic [31:0] retired;

    int tests;
    int fails;

    pc_fetch #(
        .ADDR_W   (8),
        .RESET_PC (8'h00),
        .HALT_OP  (6'b111111)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .jump         (jump),
        .branch_taken (branch_taken),
        .op           (op),
        .func         (func),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .imm16        (imm16),
        .pc           (pc),
        .pc_plus1     (pc_plus1),
        .valid        (valid),
        .halted       (halted),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] exp_pc,
                               input logic [31:0] exp_ret, input logic exp_halt);
        check({tag, ".pc"},      {24'd0, pc},        {24'd0, exp_pc});
        check({tag, ".addr"},    {24'd0, imem_addr}, {24'd0, exp_pc});
        check({tag, ".retired"}, retired,            exp_ret);
        check({tag, ".halted"},  {31'd0, halted},    {31'd0, exp_halt});
        check({tag, ".valid"},   {31'd0, valid},     {31'd0, ~exp_halt});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        imem_rdata = 32'h0;
        stall = 1'b0;
        jump = 1'b0;
        branch_taken = 1'b0;

        // Reset state
        #2;
        check_state("reset", 8'h00, 32'd0, 1'b0);
        rst = 1'b0;

        // Sequential fetch 0 -> 1 -> 2 -> 3
        tick(); check_state("seq1", 8'h01, 32'd1, 1'b0);
        tick(); check_state("seq2", 8'h02, 32'd2, 1'b0);
        tick(); check_state("seq3", 8'h03, 32'd3, 1'b0);

        // Field split on an LW-shaped word
        imem_rdata = 32'h8C43_28FE;
        #1;
        check("fld.op",    {26'd0, op},    32'h23);
        check("fld.rs",    {27'd0, rs},    32'd2);
        check("fld.rt",    {27'd0, rt},    32'd3);
        check("fld.rd",    {27'd0, rd},    32'd5);
        check("fld.imm16", {16'd0, imm16}, 32'h28FE);
        check("fld.func",  {28'd0, func},  32'hE);
        check("fld.pcp1",  {24'd0, pc_plus1}, 32'h04);
        tick(); check_state("seq4", 8'h04, 32'd4, 1'b0);

        // Jump from 4 to 0x20
        imem_rdata = 32'h0800_0020;
        jump = 1'b1;
        #1;
        check("jmp.op", {26'd0, op}, 32'h02);
        tick(); check_state("jmp", 8'h20, 32'd5, 1'b0);

        // Backward branch: 0x20 + 1 - 2 = 0x1F
        jump = 1'b0;
        branch_taken = 1'b1;
        imem_rdata = 32'h0000_FFFE;
        tick(); check_state("br_neg", 8'h1F, 32'd6, 1'b0);

        // Jump to 5
        branch_taken = 1'b0;
        jump = 1'b1;
        imem_rdata = 32'h0000_0005;
        tick(); check_state("jmp5", 8'h05, 32'd7, 1'b0);

        // Stall 3 cycles with jump asserted: nothing moves
        stall = 1'b1;
        imem_rdata = 32'h0000_0077;
        tick(); check_state("stall1", 8'h05, 32'd7, 1'b0);
        tick(); check_state("stall2", 8'h05, 32'd7, 1'b0);
        tick(); check_state("stall3", 8'h05, 32'd7, 1'b0);
        stall = 1'b0;
        jump = 1'b0;
        imem_rdata = 32'h0;
        tick(); check_state("unstall", 8'h06, 32'd8, 1'b0);

        // Jump to 0xFF then wrap to 0
        jump = 1'b1;
        imem_rdata = 32'h0000_00FF;
        tick(); check_state("jmpff", 8'hFF, 32'd9, 1'b0);
        check("ff.pcp1", {24'd0, pc_plus1}, 32'h00);
        jump = 1'b0;
        imem_rdata = 32'h0;
        tick(); check_state("wrap", 8'h00, 32'd10, 1'b0);

        // Jump and branch together: jump wins (branch would give 0x41)
        jump = 1'b1;
        branch_taken = 1'b1;
        imem_rdata = 32'h0000_FF40;
        tick(); check_state("jmp_wins", 8'h40, 32'd11, 1'b0);

        // Jump to 9
        branch_taken = 1'b0;
        imem_rdata = 32'h0000_0009;
        tick(); check_state("jmp9", 8'h09, 32'd12, 1'b0);

        // HALT opcode under stall: stall wins
        jump = 1'b0;
        stall = 1'b1;
        imem_rdata = 32'hFC00_000F;
        tick(); check_state("halt_stall", 8'h09, 32'd12, 1'b0);
        stall = 1'b0;
        tick(); check_state("halt", 8'h09, 32'd13, 1'b1);
        check("halt.op",   {26'd0, op},   32'd0);
        check("halt.func", {28'd0, func}, 32'd0);

        // Redirects ignored in HALT
        jump = 1'b1;
        branch_taken = 1'b1;
        imem_rdata = 32'h0000_0033;
        tick(); check_state("halt_jb1", 8'h09, 32'd13, 1'b1);
        tick(); check_state("halt_jb2", 8'h09, 32'd13, 1'b1);
        jump = 1'b0;
        branch_taken = 1'b0;
        imem_rdata = 32'h0;

        // Async reset between edges while halted
        #3;
        rst = 1'b1;
        #1;
        check_state("arst_halt", 8'h00, 32'd0, 1'b0);
        #1;
        rst = 1'b0;

        // Run two, stall, then async reset mid-stall
        tick(); check_state("post1", 8'h01, 32'd1, 1'b0);
        tick(); check_state("post2", 8'h02, 32'd2, 1'b0);
        stall = 1'b1;
        tick(); check_state("post_stall", 8'h02, 32'd2, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_state("arst_stall", 8'h00, 32'd0, 1'b0);
        #1;
        rst = 1'b0;
        stall = 1'b0;
        tick(); check_state("post_rst", 8'h01, 32'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
